uart_rx_sampler: RTL and testbench
==================================

# uart_rx_sampler

Mid-bit-sampling UART receive end for the miniUART. It recovers 8N1 frames from the serial line driven by the transmitter, validates the start and stop bits, and presents each byte through a one-entry valid/ready output buffer. The buffer reports framing errors and overruns. It sits between the serial pin and any byte consumer: a loopback/echo path, a FIFO or a test-bench checker.

## Interface
Parameters:
- CLKS_PER_BIT, 16: clock cycles per serial bit. Even, minimum 4.
- HALF_BIT, CLKS_PER_BIT/2: offset from the detected start edge to the mid-start sample. Derived; not overridden.

Ports:
- clock, input, 1: single clock; all state updates on its rising edge.
- reset, input, 1: asynchronous, active-high reset.
- serial_input, input, 1: asynchronous serial line; idles high.
- rx_byte, output, 8: last accepted byte, LSB received first.
- rx_valid, output, 1: rx_byte holds an unconsumed byte.
- rx_ready, input, 1: consumer accepts rx_byte when rx_valid && rx_ready.
- frame_error, output, 1: one-cycle pulse when the stop bit samples low.
- overrun, output, 1: one-cycle pulse when a good frame is dropped because the buffer is full.

## Operation
- Input path: two-flop synchronizer on serial_input giving `rx_s`. Both flops reset to 1.
- Reset values: state IDLE, counters 0, rx_byte 8'h00, rx_valid 0, frame_error 0, overrun 0.
- States:
  - IDLE: when `rx_s`==0, clear the bit-timer and enter START.
  - START: at timer==HALF_BIT-1, sample `rx_s`.
    - 0 → clear the timer and bit index, enter DATA.
    - 1 → false start; return to IDLE with no output.
  - DATA: every CLKS_PER_BIT cycles, shift `rx_s` into the shift register, LSB first. After bit 7, enter STOP.
  - STOP: after CLKS_PER_BIT cycles, sample `rx_s`.
    - 1 → frame good; offer it to the output buffer.
    - 0 → pulse frame_error, discard the byte.
    - Either way, return to IDLE. If the line is still low in IDLE, the next frame is detected the following cycle; no break handling.
- Output buffer:
  - A good frame with rx_valid==0 loads rx_byte and sets rx_valid.
  - A good frame with rx_valid==1 and no handshake that cycle pulses overrun. The old byte is kept and the new byte is dropped.
  - Good frame and handshake in the same cycle: the new byte loads, rx_valid stays 1, no overrun.
  - Handshake with no new frame clears rx_valid. rx_byte holds its value.
  - A frame_error never touches rx_byte or rx_valid.
- Reset mid-frame aborts immediately. After release, reception starts only on a fresh low in IDLE.

## Timing
- Let T0 be the first cycle in IDLE with `rx_s`==0. The pin falls 2 cycles earlier because of the synchronizer.
- Sample points, relative to T0:
  - Start sample: T0+HALF_BIT.
  - Data bit n (n=0..7): T0+HALF_BIT+(n+1)·CLKS_PER_BIT.
  - Stop sample: T0+HALF_BIT+9·CLKS_PER_BIT.
- rx_valid, frame_error and overrun are registered. They go high on the cycle after the stop sample.
- Pin-to-rx_valid latency: 2 + HALF_BIT + 9·CLKS_PER_BIT + 1 cycles. With the default (16) that is 155 cycles.
- Timer width: $clog2(CLKS_PER_BIT). The bit index is 3 bits and wraps 7→0 on leaving DATA.
- rx_ready is sampled every cycle; no combinational path from rx_ready to any output.

## Structure
- Shared package `uart_pkg`:
  - state encoding (IDLE, START, DATA, STOP);
  - DATA_BITS = 8;
  - line idle level = 1.
- The transmitter reuses this package.
- One natural sub-module: `uart_bit_timer`, a count-to-N tick generator with synchronous clear. It can be shared with the transmitter.

## Test plan
- Good frame: transmitter sends 230 (8'hE6), rx_ready=1 → rx_valid pulses 1 cycle with rx_byte=8'hE6 exactly 155 cycles after the start edge. No error flags.
- False start: 3-cycle low glitch on serial_input → no rx_valid, no frame_error, state back in IDLE. Then a frame of 8'h55 is received correctly.
- Framing error: frame 8'hA3 with the stop bit forced low → frame_error pulses once, rx_valid stays 0, rx_byte unchanged.
- Overrun: two back-to-back frames 8'h01 then 8'h02 with rx_ready=0 → rx_byte=8'h01, rx_valid=1 and one overrun pulse at the end of frame 2. Next, assert rx_ready=1 for one cycle → rx_valid=0.
- Simultaneous: rx_ready pulsed on the exact completion cycle of frame 8'h7F while 8'h10 is buffered → rx_byte=8'h7F, rx_valid stays 1, no overrun.
- Reset mid-frame: reset asserted during data bit 4 of 8'hFF → all outputs return to their reset values asynchronously. A following frame 8'h3C is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the miniUART receive and transmit ends.
package uart_pkg;

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} uart_state_e;

   localparam int unsigned DATA_BITS = 8;
   localparam logic        LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running count-to-N tick generator with synchronous clear.
module uart_bit_timer #(
   parameter  int unsigned N = 16,
   localparam int unsigned W = $clog2(N)
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         clear,
   output logic [W-1:0] count,
   output logic         tick
);

   logic [W-1:0] count_q, count_d;

   assign count = count_q;
   assign tick  = (count_q == W'(N - 1));

   always_comb begin
      count_d = count_q + W'(1);
      if (clear || tick) count_d = '0;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) count_q <= '0;
      else       count_q <= count_d;
   end

endmodule

// File: rtl/uart_rx_sampler.sv
// Mid-bit-sampling 8N1 UART receiver with a one-entry valid/ready output buffer.
module uart_rx_sampler
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 serial_input,
   output logic [DATA_BITS-1:0] rx_byte,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_error,
   output logic                 overrun
);

   localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
   localparam int unsigned TW       = $clog2(CLKS_PER_BIT);

   logic                 sync_q, rx_s_q;
   uart_state_e          state_q, state_d;
   logic [2:0]           bit_idx_q, bit_idx_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic [DATA_BITS-1:0] rx_byte_q, rx_byte_d;
   logic                 rx_valid_q, rx_valid_d;
   logic                 frame_error_q, overrun_q;
   logic                 timer_clear, shift_en, frame_good, frame_bad;
   logic [TW-1:0]        count;
   logic                 tick;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_q <= LINE_IDLE;
         rx_s_q <= LINE_IDLE;
      end else begin
         sync_q <= serial_input;
         rx_s_q <= sync_q;
      end
   end

   uart_bit_timer #(.N(CLKS_PER_BIT)) u_timer (
      .clock (clock),
      .reset (reset),
      .clear (timer_clear),
      .count (count),
      .tick  (tick)
   );

   always_comb begin
      state_d     = state_q;
      bit_idx_d   = bit_idx_q;
      timer_clear = 1'b0;
      shift_en    = 1'b0;
      frame_good  = 1'b0;
      frame_bad   = 1'b0;
      unique case (state_q)
         StIdle: begin
            // Timer held at zero so START counts from the detected edge.
            timer_clear = 1'b1;
            if (!rx_s_q) state_d = StStart;
         end
         StStart: begin
            if (count == TW'(HALF_BIT - 1)) begin
               timer_clear = 1'b1;
               bit_idx_d   = 3'd0;
               state_d     = rx_s_q ? StIdle : StData;
            end
         end
         StData: begin
            if (tick) begin
               shift_en  = 1'b1;
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'(DATA_BITS - 1)) state_d = StStop;
            end
         end
         StStop: begin
            if (tick) begin
               frame_good = rx_s_q;
               frame_bad  = !rx_s_q;
               state_d    = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign shreg_d = shift_en ? {rx_s_q, shreg_q[DATA_BITS-1:1]} : shreg_q;

   // A same-cycle handshake frees the slot, so a finishing frame can load instead of overrunning.
   always_comb begin
      rx_byte_d  = rx_byte_q;
      rx_valid_d = rx_valid_q;
      if (frame_good && (!rx_valid_q || rx_ready)) begin
         rx_byte_d  = shreg_q;
         rx_valid_d = 1'b1;
      end else if (rx_valid_q && rx_ready) begin
         rx_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= StIdle;
         bit_idx_q     <= 3'd0;
         shreg_q       <= '0;
         rx_byte_q     <= '0;
         rx_valid_q    <= 1'b0;
         frame_error_q <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         bit_idx_q     <= bit_idx_d;
         shreg_q       <= shreg_d;
         rx_byte_q     <= rx_byte_d;
         rx_valid_q    <= rx_valid_d;
         frame_error_q <= frame_bad;
         overrun_q     <= frame_good && rx_valid_q && !rx_ready;
      end
   end

   assign rx_byte     = rx_byte_q;
   assign rx_valid    = rx_valid_q;
   assign frame_error = frame_error_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Scoreboard bench: frame-level reference model predicts buffer events, monitor compares.
module tb_uart_rx_sampler;

   localparam int unsigned C    = 16;
   localparam int unsigned HALF = C / 2;
   localparam int          LAT  = 2 + HALF + 9 * C + 1;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       serial_input = 1'b1;
   logic       rx_ready = 1'b0;
   logic [7:0] rx_byte;
   logic       rx_valid, frame_error, overrun;

   uart_rx_sampler #(.CLKS_PER_BIT(C)) dut (
      .clock        (clock),
      .reset        (reset),
      .serial_input (serial_input),
      .rx_byte      (rx_byte),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .frame_error  (frame_error),
      .overrun      (overrun)
   );

   always #5 clock = ~clock;

   typedef enum int {EvLoad, EvFerr, EvOvr} ev_kind_e;
   typedef struct {
      ev_kind_e   kind;
      logic [7:0] data;
      int         edge_n;
   } ev_t;

   ev_t        exp_q[$];
   logic [8:0] sched[int];  // completion edge -> {stop bit, byte}
   int         edge_cnt = 0;
   int         checks = 0;
   int         errors = 0;
   bit         model_full = 1'b0;
   logic [7:0] model_byte = 8'h00;
   int         ready_mode = 0;
   int         pulse_edge = -1;
   bit         pulse_next = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_cnt);
      end
   endtask

   task automatic push_ev(input ev_kind_e k, input logic [7:0] d, input int n);
      ev_t e;
      e.kind   = k;
      e.data   = d;
      e.edge_n = n;
      exp_q.push_back(e);
   endtask

   // Reference model: evaluated at each rising edge with the inputs seen at that edge.
   initial begin
      logic [8:0] f;
      forever begin
         @(posedge clock);
         edge_cnt++;
         if (reset) begin
            model_full = 1'b0;
            model_byte = 8'h00;
         end else if (sched.exists(edge_cnt)) begin
            f = sched[edge_cnt];
            sched.delete(edge_cnt);
            if (!f[8]) begin
               push_ev(EvFerr, 8'h00, edge_cnt);
               if (model_full && rx_ready) model_full = 1'b0;
            end else if (!model_full || rx_ready) begin
               push_ev(EvLoad, f[7:0], edge_cnt);
               model_full = 1'b1;
               model_byte = f[7:0];
            end else begin
               push_ev(EvOvr, 8'h00, edge_cnt);
            end
         end else if (model_full && rx_ready) begin
            model_full = 1'b0;
         end
      end
   end

   task automatic observe(input ev_kind_e k, input logic [7:0] d);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL event: got kind %0d data 0x%0h at edge %0d, expected none",
                  k, d, edge_cnt);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != k || e.edge_n != edge_cnt || (k == EvLoad && e.data !== d)) begin
            errors++;
            $display("FAIL event: got kind %0d data 0x%0h edge %0d, expected kind %0d data 0x%0h edge %0d",
                     k, d, edge_cnt, e.kind, e.data, e.edge_n);
         end
      end
   endtask

   // Monitor: rx_ready only changes on falling edges, so here it still shows the value of this edge.
   initial begin
      bit prev_valid = 1'b0;
      forever begin
         @(posedge clock);
         #1;
         if (reset) begin
            prev_valid = 1'b0;
         end else begin
            while (exp_q.size() > 0 && exp_q[0].edge_n < edge_cnt) begin
               checks++;
               errors++;
               $display("FAIL missed event: got nothing, expected kind %0d data 0x%0h at edge %0d",
                        exp_q[0].kind, exp_q[0].data, exp_q[0].edge_n);
               void'(exp_q.pop_front());
            end
            if (frame_error) observe(EvFerr, 8'h00);
            if (overrun) observe(EvOvr, 8'h00);
            if (rx_valid && (!prev_valid || rx_ready)) observe(EvLoad, rx_byte);
            check("rx_valid", 32'(rx_valid), 32'(model_full));
            check("rx_byte", 32'(rx_byte), 32'(model_byte));
            prev_valid = rx_valid;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clock);
         case (ready_mode)
            0:       rx_ready = 1'b0;
            1:       rx_ready = 1'b1;
            2:       rx_ready = 1'($urandom_range(0, 1));
            default: rx_ready = (edge_cnt + 1 == pulse_edge);
         endcase
      end
   end

   task automatic send_frame(input logic [7:0] b, input logic stop, input int abort_bit,
                             input int idle_after);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      @(negedge clock);
      if (abort_bit < 0) sched[edge_cnt + LAT] = {stop, b};
      if (pulse_next) begin
         pulse_edge = edge_cnt + LAT;
         pulse_next = 1'b0;
      end
      for (int i = 0; i < 10; i++) begin
         serial_input = f[i];
         if (i == abort_bit) begin
            repeat (HALF) @(negedge clock);
            reset = 1'b1;
            #1;
            check("abort rx_valid", 32'(rx_valid), 32'(0));
            check("abort rx_byte", 32'(rx_byte), 32'(0));
            check("abort frame_error", 32'(frame_error), 32'(0));
            check("abort overrun", 32'(overrun), 32'(0));
            repeat (2) @(negedge clock);
            serial_input = 1'b1;
            reset = 1'b0;
            return;
         end
         repeat (C) @(negedge clock);
      end
      serial_input = 1'b1;
      repeat (idle_after) @(negedge clock);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL timeout: got no end of stimulus, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(negedge clock);
      check("reset rx_valid", 32'(rx_valid), 32'(0));
      check("reset rx_byte", 32'(rx_byte), 32'(0));
      check("reset frame_error", 32'(frame_error), 32'(0));
      check("reset overrun", 32'(overrun), 32'(0));
      reset = 1'b0;
      repeat (5) @(negedge clock);

      ready_mode = 1;
      send_frame(8'hE6, 1'b1, -1, C);

      serial_input = 1'b0;
      repeat (3) @(negedge clock);
      serial_input = 1'b1;
      repeat (40) @(negedge clock);
      check("false start rx_valid", 32'(rx_valid), 32'(0));
      send_frame(8'h55, 1'b1, -1, C);

      ready_mode = 0;
      send_frame(8'hA3, 1'b0, -1, C);
      check("ferr rx_byte kept", 32'(rx_byte), 32'(8'h55));

      send_frame(8'h01, 1'b1, -1, 0);
      send_frame(8'h02, 1'b1, -1, C);
      check("overrun rx_byte", 32'(rx_byte), 32'(8'h01));
      check("overrun rx_valid", 32'(rx_valid), 32'(1));
      pulse_edge = edge_cnt + 3;
      ready_mode = 3;
      repeat (6) @(negedge clock);
      check("drain rx_valid", 32'(rx_valid), 32'(0));

      ready_mode = 0;
      send_frame(8'h10, 1'b1, -1, C);
      ready_mode = 3;
      pulse_next = 1'b1;
      send_frame(8'h7F, 1'b1, -1, C);
      check("simul rx_byte", 32'(rx_byte), 32'(8'h7F));
      check("simul rx_valid", 32'(rx_valid), 32'(1));

      ready_mode = 0;
      send_frame(8'hFF, 1'b1, 5, 0);
      repeat (5) @(negedge clock);
      ready_mode = 1;
      send_frame(8'h3C, 1'b1, -1, C);

      for (int k = 0; k < 30; k++) begin
         ready_mode = int'($urandom_range(0, 2));
         if ($urandom_range(0, 5) == 0) begin
            serial_input = 1'b0;
            repeat ($urandom_range(1, 4)) @(negedge clock);
            serial_input = 1'b1;
            repeat (40) @(negedge clock);
         end
         send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 7) != 0), -1,
                    int'($urandom_range(C, 3 * C)));
      end

      ready_mode = 1;
      repeat (LAT + 50) @(negedge clock);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL pending events: got %0d left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
